// File: rtl/ram_burst_reader.sv
// ram_burst_reader: read-side sequencer for a single-port synchronous-read RAM.
//
// Accepts a burst request (start address, length), walks the RAM address one
// word per issue, captures the RAM read data one cycle after each address is
// presented, and delivers the words on a valid/ready stream with a last flag.
// A 2-entry output buffer plus a one-deep in-flight read give full-rate
// streaming under continuous ready and lossless behaviour under backpressure.
//
// Build option:
//   RDR_ADDR_WRAP_EN  defined   -> addresses wrap modulo 2^AWIDTH, any length
//                                  is accepted (long bursts reread cyclically).
//                     undefined -> a request running past the top of memory
//                                  is rejected with a one-cycle err pulse.

module ram_burst_reader #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32,
    parameter int LWIDTH = AWIDTH + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [LWIDTH-1:0] burst_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;

    // Words still to be issued to the RAM for the current burst.
    logic [LWIDTH-1:0] remaining;

    // Read issued at the previous edge; its data is on ram_dout this cycle.
    logic              rd_vld_p1;
    logic              rd_last_p1;

    // Two-entry output buffer, head entry drives the stream.
    logic [1:0]        occ;
    logic [DWIDTH-1:0] head_data;
    logic [DWIDTH-1:0] tail_data;
    logic              head_last;
    logic              tail_last;

    logic              push;
    logic              pop;
    logic [2:0]        pending;
    logic              issue;
    logic              last_issue;
    logic              req_reject;

    // The RAM is only ever read from this port.
    assign ram_we = 1'b0;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head_data;
    assign m_last  = m_valid && head_last;

    assign push = rd_vld_p1;
    assign pop  = m_valid && m_ready;

    // Words that will occupy the buffer after this edge if no new read is
    // issued: buffered + in flight - leaving. A new read is only issued when
    // there is guaranteed room for its data one cycle later, so the buffer
    // can never overflow regardless of downstream stalls.
    assign pending    = {1'b0, occ} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign issue      = (state == READ) && (pending < 3'd2);
    assign last_issue = issue && (remaining == LWIDTH'(1));

`ifdef RDR_ADDR_WRAP_EN
    // Address counter wraps naturally; every non-empty request is accepted.
    assign req_reject = 1'b0;
`else
    // Reject any request whose last word would lie beyond the top of memory.
    // The sum is formed one bit wider than the length so it cannot overflow.
    localparam logic [LWIDTH:0] DEPTH_EXT = (LWIDTH + 1)'(1) << AWIDTH;
    logic [LWIDTH:0] req_end;
    assign req_end    = (LWIDTH + 1)'(start_addr) + (LWIDTH + 1)'(burst_len);
    assign req_reject = (req_end > DEPTH_EXT);
`endif

    // Control FSM: request acceptance, read issue, burst completion pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ram_addr   <= '0;
            remaining  <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            rd_vld_p1  <= issue;
            rd_last_p1 <= last_issue;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else if (req_reject) begin
                            err <= 1'b1;
                        end else begin
                            ram_addr  <= start_addr;
                            remaining <= burst_len;
                            state     <= READ;
                            busy      <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (issue) begin
                        ram_addr  <= ram_addr + AWIDTH'(1);
                        remaining <= remaining - LWIDTH'(1);
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The last-tagged word can only be at the head once all
                    // earlier words have left, so its pop ends the burst.
                    if (pop && head_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer: capture in-flight RAM data, shift toward the head on pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= ram_dout;
                        head_last <= rd_last_p1;
                    end else begin
                        tail_data <= ram_dout;
                        tail_last <= rd_last_p1;
                    end
                    occ <= occ + 2'd1;
                end

                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end

                2'b11: begin
                    // Occupancy is unchanged; new word lands behind whatever
                    // remains after the head leaves.
                    if (occ == 2'd1) begin
                        head_data <= ram_dout;
                        head_last <= rd_last_p1;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= ram_dout;
                        tail_last <= rd_last_p1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: directed scenarios plus randomized bursts,
// checked against a word-sequence model of the expected stream.

module tb_ram_burst_reader;

    localparam int AWIDTH = 3;
    localparam int DWIDTH = 32;
    localparam int LWIDTH = AWIDTH + 1;
    localparam int DEPTH  = 1 << AWIDTH;

`ifdef RDR_ADDR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              start;
    logic [AWIDTH-1:0] start_addr;
    logic [LWIDTH-1:0] burst_len;
    logic              busy;
    logic              done;
    logic              err;
    logic [AWIDTH-1:0] ram_addr;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    int checks = 0;
    int errors = 0;

    logic [DWIDTH-1:0] mem [DEPTH];

    ram_burst_reader #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH),
        .LWIDTH(LWIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .start_addr(start_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: data for the address presented at an edge
    // appears after that edge.
    always @(posedge clock) begin
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // mode: 0 = ready always 1, 1 = ready pattern 1,0,0,1,0,1, 2 = random.
    // restart_at >= 0 re-pulses start (other address) at that cycle.
    task automatic run_burst(input int addr, input int len, input int mode, input int restart_at);
        logic [AWIDTH-1:0] addr_before;
        logic [5:0]        pat;
        logic [31:0]       prev;
        logic [31:0]       expw;
        bit                accept;
        bit                seen;
        bit                stalled;
        bit                finished;
        bit                done_exp;
        bit                r;
        int                k;
        int                idx;

        pat         = 6'b100101;
        addr_before = ram_addr;
        accept      = (len != 0) && (WRAP || (addr + len <= DEPTH));
        start       = 1'b1;
        start_addr  = AWIDTH'(addr);
        burst_len   = LWIDTH'(len);
        m_ready     = 1'b1;
        step();
        start = 1'b0;

        if (len == 0) begin
            check("zero_len_done", 32'(done), 32'd1);
            check("zero_len_flags", 32'({err, busy, m_valid}), 32'd0);
            check("zero_len_addr", 32'(ram_addr), 32'(addr_before));
            step();
            check("zero_len_after", 32'({done, m_valid, busy}), 32'd0);
            return;
        end

        if (!accept) begin
            check("reject_err", 32'(err), 32'd1);
            check("reject_flags", 32'({done, busy, m_valid}), 32'd0);
            for (int i = 0; i < 3; i++) begin
                step();
                check("reject_quiet", 32'({err, busy, m_valid}), 32'd0);
            end
            return;
        end

        k        = 0;
        idx      = 0;
        seen     = 1'b0;
        stalled  = 1'b0;
        finished = 1'b0;
        done_exp = 1'b0;
        prev     = '0;
        check("busy_after_start", 32'(busy), 32'd1);

        while (!finished && k < 20 * len + 20) begin
            if (done_exp) begin
                start = 1'b0;
                check("done_pulse", 32'({done, busy, m_valid}), 32'b100);
                if (mode == 0) check("done_latency", 32'(k), 32'(len + 2));
                finished = 1'b1;
            end else begin
                check("no_pulse", 32'({done, err, ram_we}), 32'd0);
                if (m_valid && !seen) begin
                    seen = 1'b1;
                    check("first_valid_latency", 32'(k), 32'd2);
                end
                if (stalled) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", m_data, prev);
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = pat[k % 6];
                    default: r = 1'($urandom_range(0, 1));
                endcase
                m_ready = r;
                if (restart_at == k) begin
                    start      = 1'b1;
                    start_addr = AWIDTH'(addr + 3);
                    burst_len  = LWIDTH'(2);
                end else begin
                    start = 1'b0;
                end
                if (m_valid && r) begin
                    expw = 32'hA0 + 32'((addr + idx) % DEPTH);
                    check("data", m_data, expw);
                    check("last", 32'(m_last), 32'(idx == len - 1));
                    idx++;
                    if (idx == len) done_exp = 1'b1;
                end
                stalled = m_valid && !r;
                prev    = m_data;
                step();
                k++;
            end
        end

        check("burst_timeout", 32'(finished), 32'd1);
        check("word_count", 32'(idx), 32'(len));
        m_ready = 1'b1;
        start   = 1'b0;
        step();
        check("post_done", 32'({done, m_valid, busy}), 32'd0);
    endtask

    initial begin
        int pops;
        int k;

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA0 + 32'(i);
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        burst_len  = '0;
        m_ready    = 1'b1;
        step();
        step();

        // Reset state.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_stream", 32'({m_valid, m_last}), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        reset = 1'b0;
        step();

        // Basic burst, full rate.
        run_burst(2, 3, 0, -1);
        // Same burst under backpressure pattern.
        run_burst(2, 3, 1, -1);
        // Zero length: done only, address untouched.
        run_burst(0, 0, 0, -1);
        // Crossing the top of memory: wraps or is rejected.
        run_burst(6, 4, 0, -1);

        // Reset after the 2nd word of an 8-word burst.
        start      = 1'b1;
        start_addr = '0;
        burst_len  = LWIDTH'(8);
        m_ready    = 1'b1;
        step();
        start = 1'b0;
        pops  = 0;
        k     = 0;
        while (pops < 2 && k < 40) begin
            if (m_valid) pops++;
            step();
            k++;
        end
        check("mid_reset_reach", 32'(pops), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_outputs", 32'({m_valid, busy, done, m_last}), 32'd0);
        check("mid_reset_addr", 32'(ram_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_reset_quiet", 32'({m_valid, busy}), 32'd0);
        end
        run_burst(0, 2, 0, -1);

        // Start re-pulsed mid-burst is ignored.
        run_burst(1, 5, 0, 3);
        // Full-depth burst with random backpressure.
        run_burst(0, 8, 2, -1);

        // Randomized bursts.
        for (int n = 0; n < 10; n++) begin
            int a;
            int l;
            int m;
            a = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(0, WRAP ? 12 : DEPTH));
            m = int'($urandom_range(0, 2));
            run_burst(a, l, m, (n % 3 == 0) ? 2 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
Read-side sequencer that sits directly in front of the single-port synchronous-read RAM. It accepts a burst request (start address, length), drives the RAM address and write-enable, and captures RAM read data one cycle after each address is latched. It delivers the words as a valid/ready stream with a last-word flag and full backpressure support. It is the standard consumer of the data RAM in the read datapath.

Parameters:
AWIDTH, 3, RAM address width; memory depth = 2^AWIDTH
DWIDTH, 32, RAM/stream data width
LWIDTH, AWIDTH+1, burst length width (allows a length of exactly 2^AWIDTH)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  burst request, sampled in IDLE only
start_addr  input  AWIDTH  first word address
burst_len  input  LWIDTH  number of words to read
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse when a burst completes
err  output  1  one-cycle pulse when a request is rejected
ram_addr  output  AWIDTH  registered address to RAM addr
ram_we  output  1  RAM write enable, constant 0
ram_dout  input  DWIDTH  RAM read data (valid the cycle after ram_addr is latched)
m_data  output  DWIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready from downstream
m_last  output  1  high with the final word of the burst

Behaviour:
- Reset values: busy=0, done=0, err=0, ram_addr=0, ram_we=0, m_valid=0, m_last=0, m_data=0. The buffer is emptied, the in-flight flag is cleared and the FSM goes to IDLE.
- FSM states: IDLE, READ, DRAIN.
- IDLE: when start=1:
  - burst_len=0 -> done pulses on the next cycle, no reads, stay IDLE.
  - Rejected request (see Optional Feature) -> err pulses on the next cycle, stay IDLE.
  - Otherwise ram_addr<=start_addr, remaining<=burst_len, go to READ.
- Issue rule: issue = (state==READ) && (occ + inflight - pop < 2).
  - occ is the output-buffer count (0..2). pop is m_valid&&m_ready.
  - On an issue edge: inflight<=1, ram_addr<=ram_addr+1 (mod 2^AWIDTH), remaining<=remaining-1.
  - On a non-issue edge: inflight<=0.
- Capture: when inflight=1, ram_dout is written into a 2-entry FIFO at the edge. The entry is tagged last if it is the final issued word.
- READ -> DRAIN on the edge that issues the last word.
- DRAIN -> IDLE on the edge where the last-tagged word pops; done pulses in the following cycle.
- busy covers READ and DRAIN. busy is 0 during the done cycle.
- Stream: m_valid=occ!=0, and m_data/m_last come from the FIFO head.
  - Head data is held stable while m_valid=1 and m_ready=0.
  - Push and pop in the same cycle are legal and leave occ unchanged.
- Latency: start sampled at edge E0 -> m_valid high after edge E2.
  - With m_ready held at 1, one word per cycle.
  - An N-word burst ends with m_last on word N and done after edge E(N+2).
- start while busy is ignored (no err).
- Reset mid-burst: m_valid=0 and busy=0 after the reset edge. No further words are output, even if a read was in flight.

Optional Feature:
Macro RDR_ADDR_WRAP_EN.
- Defined: addresses wrap from 2^AWIDTH-1 to 0. Any burst_len is accepted, and lengths above depth reread words cyclically.
- Undefined: a request with start_addr + burst_len > 2^AWIDTH (computed at LWIDTH+1 bits) is rejected with an err pulse and no RAM reads.

Test Plan:
- RAM preloaded mem[k]=32'hA0+k; start_addr=2, burst_len=3, m_ready=1 -> m_data A2,A3,A4 on consecutive cycles starting after E2; m_last on A4; done one cycle after the A4 pop.
- Same burst with m_ready toggled 1,0,0,1,0,1 -> same data order, none lost or duplicated, m_data stable while stalled, occ never above 2.
- burst_len=0 -> done pulse one cycle later, m_valid never rises, ram_addr unchanged.
- start_addr=6, burst_len=4 -> with macro: data A6,A7,A0,A1. Without macro: err pulse, busy stays 0, no m_valid.
- reset asserted for one cycle after the 2nd word of an 8-word burst -> m_valid=0, busy=0 after the reset edge; a new burst (addr 0, len 2) then returns A0,A1 correctly.
- start re-pulsed mid-burst (different addr) -> ignored, original burst completes intact, err stays 0.
